// File: rtl/mem_access_unit.sv
// Load/store bridge between a core valid/ready port and a word-organised synchronous RAM.
// Handles byte..dword sizes, sign/zero extension, and word-crossing accesses split into two RAM cycles.
module mem_access_unit #(
  parameter int unsigned ADDR_W           = 16,
  parameter int unsigned DATA_W           = 16,
  parameter bit          ALLOW_MISALIGNED = 1'b1,
  localparam int unsigned NB = DATA_W / 8,
  localparam int unsigned OB = $clog2(NB),
  localparam int unsigned WA = ADDR_W - OB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [NB-1:0]     mem_be,
  output logic [WA-1:0]     mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    ACC1,
    ACC2,
    WAIT,
    RESP
  } state_t;

  state_t state, state_next;

  // Request decode (combinational, only meaningful while IDLE)
  logic [OB-1:0] dec_off;
  logic [3:0]    dec_bytes;
  logic          dec_oversize;
  logic          dec_split;
  logic          dec_illegal;

  assign dec_off      = req_addr[OB-1:0];
  assign dec_bytes    = 4'd1 << req_size;
  assign dec_oversize = 32'(dec_bytes) > NB;
  assign dec_split    = (32'(dec_off) + 32'(dec_bytes)) > NB;
  assign dec_illegal  = dec_oversize || (dec_split && !ALLOW_MISALIGNED);

  // Latched request
  logic              r_we;
  logic [1:0]        r_size;
  logic              r_signed;
  logic [OB-1:0]     r_off;
  logic [WA-1:0]     r_w0;
  logic [WA-1:0]     r_w1;
  logic [DATA_W-1:0] r_wdata;
  logic              r_split;
  logic              r_err;
  logic [DATA_W-1:0] r_word0;
  logic [DATA_W-1:0] r_result;
  logic [3:0]        r_bytes;

  assign r_w1    = r_w0 + WA'(1);
  assign r_bytes = 4'd1 << r_size;

  // Store lane placement across the two-word window
  logic [NB-1:0]       lane_ones;
  logic [2*NB-1:0]     lane_mask;
  logic [2*DATA_W-1:0] lane_data;

  always_comb begin
    lane_ones = '0;
    for (int unsigned i = 0; i < NB; i++) begin
      lane_ones[i] = (i < 32'(r_bytes));
    end
    lane_mask = {{NB{1'b0}}, lane_ones} << r_off;
    lane_data = {{DATA_W{1'b0}}, r_wdata} << {r_off, 3'b000};
  end

  // Load assembly: the last word arrives on mem_rdata during WAIT
  logic [DATA_W-1:0]   word_lo;
  logic [DATA_W-1:0]   word_hi;
  logic [2*DATA_W-1:0] shifted;
  logic                sign_bit;
  logic [DATA_W-1:0]   load_ext;

  always_comb begin
    word_lo  = r_split ? r_word0 : mem_rdata;
    word_hi  = r_split ? mem_rdata : '0;
    shifted  = {word_hi, word_lo} >> {r_off, 3'b000};
    sign_bit = 1'b0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i == (32'(r_bytes) << 3) - 1) sign_bit = shifted[i];
    end
    load_ext = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      load_ext[i] = (i < (32'(r_bytes) << 3)) ? shifted[i] : (r_signed & sign_bit);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_err   = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_be     = '0;
    mem_addr   = '0;
    mem_wdata  = '0;
    unique case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_next = dec_illegal ? RESP : ACC1;
      end
      ACC1: begin
        mem_en   = 1'b1;
        mem_addr = r_w0;
        if (r_we) begin
          mem_we    = 1'b1;
          mem_be    = lane_mask[NB-1:0];
          mem_wdata = lane_data[DATA_W-1:0];
        end
        state_next = r_split ? ACC2 : WAIT;
      end
      ACC2: begin
        mem_en   = 1'b1;
        mem_addr = r_w1;
        if (r_we) begin
          mem_we    = 1'b1;
          mem_be    = lane_mask[2*NB-1:NB];
          mem_wdata = lane_data[2*DATA_W-1:DATA_W];
        end
        state_next = WAIT;
      end
      WAIT: state_next = RESP;
      RESP: begin
        resp_valid = 1'b1;
        resp_rdata = r_result;
        resp_err   = r_err;
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Result stays zero for stores and errors: it is cleared on accept and only loads write it
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_we     <= 1'b0;
      r_size   <= '0;
      r_signed <= 1'b0;
      r_off    <= '0;
      r_w0     <= '0;
      r_wdata  <= '0;
      r_split  <= 1'b0;
      r_err    <= 1'b0;
      r_word0  <= '0;
      r_result <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            r_we     <= req_we;
            r_size   <= req_size;
            r_signed <= req_signed;
            r_off    <= dec_off;
            r_w0     <= req_addr[ADDR_W-1:OB];
            r_wdata  <= req_wdata;
            r_split  <= dec_split;
            r_err    <= dec_illegal;
            r_result <= '0;
          end
        end
        ACC2: if (!r_we) r_word0 <= mem_rdata;
        WAIT: if (!r_we) r_result <= load_ext;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Bench for mem_access_unit: directed cases plus randomized loads/stores against a byte-addressed memory model.
module tb_mem_access_unit;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_valid, req_ready, req_we, req_signed;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid, resp_ready, resp_err;
  logic [DW-1:0] resp_rdata;
  logic          mem_en, mem_we;
  logic [1:0]    mem_be;
  logic [14:0]   mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Second instance with misalignment disallowed; fixed RAM read data
  logic          na_req_valid, na_req_ready, na_req_we, na_req_signed;
  logic [1:0]    na_req_size;
  logic [AW-1:0] na_req_addr;
  logic [DW-1:0] na_req_wdata;
  logic          na_resp_valid, na_resp_ready, na_resp_err;
  logic [DW-1:0] na_resp_rdata;
  logic          na_mem_en, na_mem_we;
  logic [1:0]    na_mem_be;
  logic [14:0]   na_mem_addr;
  logic [DW-1:0] na_mem_wdata, na_mem_rdata;

  mem_access_unit #(.ADDR_W(AW), .DATA_W(DW), .ALLOW_MISALIGNED(1'b0)) u_dut_na (
    .clk(clk), .rst(rst),
    .req_valid(na_req_valid), .req_ready(na_req_ready), .req_we(na_req_we), .req_size(na_req_size),
    .req_signed(na_req_signed), .req_addr(na_req_addr), .req_wdata(na_req_wdata),
    .resp_valid(na_resp_valid), .resp_ready(na_resp_ready), .resp_rdata(na_resp_rdata),
    .resp_err(na_resp_err),
    .mem_en(na_mem_en), .mem_we(na_mem_we), .mem_be(na_mem_be), .mem_addr(na_mem_addr),
    .mem_wdata(na_mem_wdata), .mem_rdata(na_mem_rdata)
  );

  // Word RAM seen by the main instance
  logic        ram_clr;
  logic [15:0] ram [0:32767];
  logic [15:0] ram_q = 16'h0;
  assign mem_rdata = ram_q;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32768; i++) ram[i] <= 16'h0;
    end else if (mem_en) begin
      if (mem_we) begin
        if (mem_be[0]) ram[mem_addr][7:0]  <= mem_wdata[7:0];
        if (mem_be[1]) ram[mem_addr][15:8] <= mem_wdata[15:8];
      end else begin
        ram_q <= ram[mem_addr];
      end
    end
  end

  // Reference: flat little-endian byte memory, byte address wraps at 2^16
  logic [7:0] ref_mem [0:65535];

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_load(input logic [15:0] a, input int unsigned nb, input bit sgn);
    logic [15:0] v;
    v = 16'h0;
    for (int unsigned k = 0; k < nb; k++) v[8*k +: 8] = ref_mem[16'(a + k)];
    if (nb == 1 && sgn && v[7]) v[15:8] = 8'hFF;
    return v;
  endfunction

  logic [14:0] en_addr [2];
  logic [1:0]  en_be   [2];
  logic [15:0] en_wd   [2];
  logic        en_we   [2];
  int unsigned en_cnt, lat;
  logic [15:0] got_rdata;
  logic        got_err;

  task automatic do_req(input bit we, input logic [1:0] size, input bit sgn,
                        input logic [15:0] addr, input logic [15:0] wd, input int unsigned hold);
    int unsigned nb;
    bit          err, split;
    logic [14:0] w0, w1, wexp;
    logic [15:0] exp_rd, ba, xwd, mask;
    logic [1:0]  xb;
    nb     = 1 << size;
    err    = (nb > 2);
    split  = !err && ((32'(addr[0]) + nb) > 2);
    w0     = addr[15:1];
    w1     = w0 + 15'd1;
    exp_rd = (err || we) ? 16'h0 : ref_load(addr, nb, sgn);

    @(negedge clk);
    check("req_ready_idle", req_ready, 1);
    req_valid = 1'b1; req_we = we; req_size = size; req_signed = sgn;
    req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_we = 1'($urandom); req_size = 2'($urandom); req_signed = 1'($urandom);
    req_addr = 16'($urandom); req_wdata = 16'($urandom);

    en_cnt = 0; lat = 0;
    while (lat < 12) begin
      @(negedge clk);
      lat++;
      if (resp_valid) break;
      if (mem_en) begin
        if (en_cnt < 2) begin
          en_addr[en_cnt] = mem_addr; en_be[en_cnt] = mem_be;
          en_wd[en_cnt] = mem_wdata;  en_we[en_cnt] = mem_we;
        end
        en_cnt++;
      end
    end
    got_rdata = resp_rdata;
    got_err   = resp_err;
    check("latency", lat, err ? 1 : (split ? 4 : 3));
    check("mem_en_cycles", en_cnt, err ? 0 : (split ? 2 : 1));
    check("resp_err", resp_err, err);
    check("resp_rdata", resp_rdata, exp_rd);

    for (int unsigned j = 0; j < en_cnt && j < 2; j++) begin
      wexp = (j == 0) ? w0 : w1;
      xb = 2'b00; xwd = 16'h0;
      for (int unsigned k = 0; k < nb; k++) begin
        ba = 16'(addr + k);
        if (ba[15:1] == wexp) begin
          xb[ba[0]] = 1'b1;
          xwd[8*ba[0] +: 8] = wd[8*k +: 8];
        end
      end
      mask = {{8{xb[1]}}, {8{xb[0]}}};
      check("mem_addr", en_addr[j], wexp);
      check("mem_we", en_we[j], we);
      check("mem_be", en_be[j], we ? xb : 2'b00);
      if (we) check("mem_wdata", en_wd[j] & mask, xwd);
    end

    if (resp_valid) begin
      for (int unsigned h = 0; h < hold; h++) begin
        @(negedge clk);
        check("hold_valid", resp_valid, 1);
        check("hold_rdata", resp_rdata, exp_rd);
        check("hold_err", resp_err, err);
        check("hold_req_ready", req_ready, 0);
      end
      resp_ready = 1'b1;
      @(posedge clk);
      #1;
      resp_ready = 1'b0;
      @(negedge clk);
      check("req_ready_after_resp", req_ready, 1);
      check("resp_valid_after_resp", resp_valid, 0);
    end

    if (we && !err) begin
      for (int unsigned k = 0; k < nb; k++) ref_mem[16'(addr + k)] = wd[8*k +: 8];
      check("ram_word0", ram[w0], {ref_mem[{w0, 1'b1}], ref_mem[{w0, 1'b0}]});
      if (split) check("ram_word1", ram[w1], {ref_mem[{w1, 1'b1}], ref_mem[{w1, 1'b0}]});
    end
  endtask

  task automatic na_req(input logic [1:0] size, input bit sgn, input logic [15:0] addr,
                        input int unsigned exp_lat, input int unsigned exp_en,
                        input bit exp_err, input logic [15:0] exp_rd);
    int unsigned n, e;
    @(negedge clk);
    na_req_valid = 1'b1; na_req_we = 1'b0; na_req_size = size; na_req_signed = sgn;
    na_req_addr = addr; na_req_wdata = 16'h0;
    @(posedge clk);
    #1;
    na_req_valid = 1'b0;
    n = 0; e = 0;
    while (n < 12) begin
      @(negedge clk);
      n++;
      if (na_resp_valid) break;
      if (na_mem_en) e++;
    end
    check("na_latency", n, exp_lat);
    check("na_mem_en_cycles", e, exp_en);
    check("na_resp_err", na_resp_err, exp_err);
    check("na_resp_rdata", na_resp_rdata, exp_rd);
  endtask

  task automatic check_reset_outputs();
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
  endtask

  logic [15:0] r_addr;
  logic [1:0]  r_size;
  int unsigned bad_cycles;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;
    rst = 1'b1; ram_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_signed = 1'b0;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    na_req_valid = 1'b0; na_req_we = 1'b0; na_req_size = 2'd0; na_req_signed = 1'b0;
    na_req_addr = '0; na_req_wdata = '0; na_resp_ready = 1'b1; na_mem_rdata = 16'hA53C;
    #1;
    check_reset_outputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ram_clr = 1'b0;

    // Populate words 0x0008/0x0009 through the DUT itself
    do_req(1'b1, 2'd1, 1'b0, 16'h0010, 16'hBEEF, 0);
    do_req(1'b1, 2'd1, 1'b0, 16'h0012, 16'h1234, 0);

    do_req(1'b0, 2'd0, 1'b0, 16'h0011, 16'h0, 0);
    check("t1_rdata", got_rdata, 16'h00BE);
    check("t1_addr", en_addr[0], 15'h0008);

    do_req(1'b0, 2'd0, 1'b1, 16'h0010, 16'h0, 0);
    check("t2_rdata", got_rdata, 16'hFFEF);

    do_req(1'b0, 2'd1, 1'b0, 16'h0011, 16'h0, 0);
    check("t3_rdata", got_rdata, 16'h34BE);
    check("t3_addr0", en_addr[0], 15'h0008);
    check("t3_addr1", en_addr[1], 15'h0009);

    do_req(1'b1, 2'd1, 1'b0, 16'hFFFF, 16'hA55A, 0);
    check("t4_addr0", en_addr[0], 15'h7FFF);
    check("t4_be0", en_be[0], 2'b10);
    check("t4_wd0", en_wd[0][15:8], 8'h5A);
    check("t4_addr1", en_addr[1], 15'h0000);
    check("t4_be1", en_be[1], 2'b01);
    check("t4_wd1", en_wd[1][7:0], 8'hA5);
    check("t4_rdata", got_rdata, 16'h0);

    do_req(1'b0, 2'd2, 1'b0, 16'h0010, 16'h0, 0);
    check("t5_err", got_err, 1);
    check("t5_rdata", got_rdata, 16'h0);

    na_req(2'd1, 1'b0, 16'h0003, 1, 0, 1'b1, 16'h0000);
    na_req(2'd1, 1'b0, 16'h0002, 3, 1, 1'b0, 16'hA53C);
    na_req(2'd0, 1'b1, 16'h0003, 3, 1, 1'b0, 16'hFFA5);
    na_req(2'd3, 1'b0, 16'h0000, 1, 0, 1'b1, 16'h0000);

    do_req(1'b0, 2'd1, 1'b1, 16'h0011, 16'h0, 5);
    check("t6_rdata", got_rdata, 16'h34BE);

    // Reset during ACC2 of a split read
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd1; req_signed = 1'b0; req_addr = 16'h0011;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    check("t7_acc1_en", mem_en, 1);
    @(posedge clk);
    #1;
    check("t7_acc2_addr", mem_addr, 15'h0009);
    rst = 1'b1;
    #1;
    check_reset_outputs();
    @(negedge clk);
    rst = 1'b0;
    bad_cycles = 0;
    repeat (8) begin
      @(negedge clk);
      if (mem_en || resp_valid || !req_ready) bad_cycles++;
    end
    check("t7_quiet_after_rst", bad_cycles, 0);

    for (int i = 0; i < 300; i++) begin
      r_addr = ($urandom_range(0, 1) != 0 ? 16'hFFF8 : 16'h0010) + 16'($urandom_range(0, 15));
      r_size = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      do_req(1'($urandom_range(0, 1)), r_size, 1'($urandom_range(0, 1)), r_addr,
             16'($urandom), $urandom_range(0, 3));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Parametrised successor to the 16-bit byte/half memory controller.
- Sits between a core load/store port and a word-organised synchronous RAM with byte-lane write strobes.
- Supports byte/half/word/dword sizes, sign or zero extension, and misaligned accesses split into two RAM cycles.
- Uses valid/ready request and response handshakes.

Parameters:
ADDR_W, 16, byte-address width
DATA_W, 16, data and RAM word width; a power of two, >=16; NB=DATA_W/8 lanes, OB=log2(NB)
ALLOW_MISALIGNED, 1, 1 = split accesses that cross a word; 0 = report them as errors

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  1  request present
req_ready  out  1  request accepted when high together with req_valid
req_we  in  1  1 = store, 0 = load
req_size  in  2  0=byte, 1=half, 2=word(32), 3=dword(64); bytes=1<<req_size
req_signed  in  1  load result is sign-extended
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, low-aligned
resp_valid  out  1  response present
resp_ready  in  1  response consumed
resp_rdata  out  DATA_W  load result, extended to DATA_W; 0 for stores and errors
resp_err  out  1  illegal size or disallowed misalignment
mem_en  out  1  RAM access this cycle
mem_we  out  1  RAM write
mem_be  out  NB  byte-lane write enables
mem_addr  out  ADDR_W-OB  word address
mem_wdata  out  DATA_W  lane-positioned write data
mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en with mem_we=0

Behaviour:
- Reset, async, takes effect immediately:
  - state=IDLE; all outputs 0 except req_ready=1.
  - Any in-flight access is abandoned and no further mem_en is issued.
- Request decode:
  - off = req_addr[OB-1:0]; w0 = req_addr[ADDR_W-1:OB]; w1 = w0+1 modulo 2^(ADDR_W-OB), so it wraps.
  - split = (off+bytes > NB).
- Error cases:
  - Illegal: bytes > NB, or split with ALLOW_MISALIGNED=0.
  - An illegal request goes IDLE->RESP with resp_err=1, resp_rdata=0 and no mem_en. resp_valid is high in the cycle after accept.
- States: IDLE, ACC1, ACC2, WAIT, RESP.
  - req_ready = (state==IDLE). All request fields are latched on accept.
  - IDLE->ACC1 on accept of a legal request.
  - ACC1 drives mem_en=1 with mem_addr=w0. Transitions to ACC2 if split, else WAIT.
  - ACC2 drives mem_en=1 with mem_addr=w1. For reads it captures mem_rdata as word0. Transitions to WAIT.
  - WAIT drives mem_en=0. For reads it captures the last word (word0 if not split, word1 if split). Transitions to RESP.
  - RESP holds resp_valid=1 with resp_rdata and resp_err stable until resp_valid&&resp_ready, then goes to IDLE.
- Latency from the accept edge E0 to resp_valid: aligned 3 cycles, split 4 cycles, error 1 cycle. Back-to-back throughput is one request per 4 or 5 cycles.
- Store lane placement:
  - W = {DATA_W'0, req_wdata} << (8*off), 2*DATA_W bits wide; L = ((1<<bytes)-1) << off, 2*NB bits wide.
  - Word0 uses mem_wdata=W[DATA_W-1:0] and mem_be=L[NB-1:0].
  - Word1 uses the upper halves of W and L.
  - Lanes outside the access are never strobed. mem_we=1 only during ACC1/ACC2 of a store; mem_be=0 whenever mem_we=0.
- Load assembly:
  - R = {word1, word0} >> (8*off); the low 8*bytes bits are zero- or sign-extended to DATA_W.
  - word1 is treated as 0 when not split.
- Store response: resp_valid with resp_rdata=0 and resp_err=0.
- Request inputs are ignored outside IDLE. mem_rdata is ignored except in the capture cycles.

Test Plan:
1. Defaults. RAM word 0x0008=0xBEEF. Load byte, unsigned, addr 0x0011 -> one mem_en cycle with mem_addr=0x0008; resp_valid 3 cycles after accept; resp_rdata=0x00BE, resp_err=0.
2. Load byte, signed, addr 0x0010, same RAM contents -> resp_rdata=0xFFEF.
3. Word 0x0008=0xBEEF, 0x0009=0x1234. Load half, unsigned, addr 0x0011 -> mem_en in two consecutive cycles at 0x0008 then 0x0009; resp_rdata=0x34BE, 4-cycle latency.
4. Store half 0xA55A at addr 0xFFFF (wrap) -> first write: mem_addr=0x7FFF, mem_be=2'b10, mem_wdata[15:8]=0x5A. Second write: mem_addr=0x0000, mem_be=2'b01, mem_wdata[7:0]=0xA5. Then resp_valid with resp_rdata=0.
5. Load word (size=2) with DATA_W=16 -> resp_err=1 one cycle after accept, no mem_en. With ALLOW_MISALIGNED=0, load half at addr 0x0003 -> resp_err=1, no mem_en.
6. Two further checks:
   - Hold resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_err stay stable and req_ready stays 0. Raising resp_ready gives req_ready=1 on the next cycle.
   - Assert rst during ACC2 of a split read -> outputs go to reset values immediately, no further mem_en, and no resp_valid.
